ofdm_tx_frame_sched: RTL

//  Frame-level scheduler at the tail of the 802.11 OFDM TX chain. Per frame: passes PRE_LEN

---
 rtl/ofdm_tx_pkg.sv | 24 ++
 rtl/tx_out_stage.sv | 51 +++++
 rtl/ofdm_tx_frame_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM TX tail: frame FSM state encoding,
// default frame geometry and the {I,Q} sample-word layout.
// Pure declarations; no logic.
package ofdm_tx_pkg;

  // Default frame geometry
  localparam int PRE_LEN_DEF = 320;  // short + long training fields
  localparam int SYM_LEN_DEF = 80;   // 64-point IFFT + 16-sample cyclic prefix
  localparam int GAP_LEN_DEF = 16;   // idle cycles between frames
  localparam int NSYM_W_DEF  = 8;    // width of the symbol-count configuration

  // Frame scheduler states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // Sample word: I in the upper half, Q in the lower half
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_smp_t;

endpackage

// File: rtl/tx_out_stage.sv
// One-entry registered Wishbone-style sample output stage.
// Latency: 1 clk from accepted input to STB_O; full throughput of 1 sample/clk.
// Backpressure: ready = ~stb_o | ack_i; entry and data held while stb_o & ~ack_i.
module tx_out_stage
  import ofdm_tx_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    in_vld_i,
  input  iq_smp_t in_dat_i,
  output logic    in_rdy_o,
  output iq_smp_t dat_o,
  output logic    stb_o,
  output logic    we_o,
  input  logic    ack_i
);

  iq_smp_t dat_q, dat_d;
  logic    stb_q, stb_d;

  // Entry can take a new sample when empty or when it drains this cycle
  assign in_rdy_o = ~stb_q | ack_i;

  // Load on an accepted input, otherwise empty the entry once acknowledged
  always_comb begin
    dat_d = dat_q;
    stb_d = stb_q;
    if (in_vld_i && in_rdy_o) begin
      dat_d = in_dat_i;
      stb_d = 1'b1;
    end else if (ack_i) begin
      stb_d = 1'b0;
    end
  end

  // Entry registers; reset drops any in-flight sample
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dat_q <= '0;
      stb_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      stb_q <= stb_d;
    end
  end

  assign dat_o = dat_q;
  assign stb_o = stb_q;
  assign we_o  = stb_q;

endmodule

// File: rtl/ofdm_tx_frame_sched.sv
// Frame scheduler: preamble samples, then NSYM*SYM_LEN data samples, then GAP_LEN idle cycles.
// Latency: 1 clk from source beat to STB_O via the registered output entry.
// Backpressure: selected source ACK only while the output entry can accept; ACK_I low stalls it.
module ofdm_tx_frame_sched
  import ofdm_tx_pkg::*;
#(
  parameter int PRE_LEN = PRE_LEN_DEF,
  parameter int SYM_LEN = SYM_LEN_DEF,
  parameter int GAP_LEN = GAP_LEN_DEF,
  parameter int NSYM_W  = NSYM_W_DEF
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              FRM_START,
  input  logic [NSYM_W-1:0] NSYM,
  input  logic [31:0]       PRE_DAT_I,
  input  logic              PRE_CYC_I,
  input  logic              PRE_STB_I,
  input  logic              PRE_WE_I,
  output logic              PRE_ACK_O,
  input  logic [31:0]       DAT_DAT_I,
  input  logic              DAT_CYC_I,
  input  logic              DAT_STB_I,
  input  logic              DAT_WE_I,
  output logic              DAT_ACK_O,
  output logic [31:0]       DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,
  output logic              BUSY,
  output logic              DONE
);

  localparam int CNT_W = $clog2((PRE_LEN > SYM_LEN) ? PRE_LEN : SYM_LEN);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;     // sample count within preamble / symbol
  logic [NSYM_W-1:0] sym_q, sym_d;     // symbol count within the data section
  logic [NSYM_W-1:0] nsym_q, nsym_d;   // symbol count latched at frame start
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              cyc_q, cyc_d;
  logic              done;

  logic    sel_pre, sel_dat;
  logic    pre_req, dat_req;
  logic    pre_beat, dat_beat;
  logic    out_vld, out_rdy;
  iq_smp_t src_dat, out_dat;

  assign sel_pre = (state_q == ST_PRE);
  assign sel_dat = (state_q == ST_DATA);

  assign pre_req = PRE_STB_I & PRE_CYC_I & PRE_WE_I;
  assign dat_req = DAT_STB_I & DAT_CYC_I & DAT_WE_I;

  // Only the source owned by the current phase is ever acknowledged
  assign pre_beat  = sel_pre & pre_req & out_rdy;
  assign dat_beat  = sel_dat & dat_req & out_rdy;
  assign PRE_ACK_O = pre_beat;
  assign DAT_ACK_O = dat_beat;

  assign out_vld = (sel_pre & pre_req) | (sel_dat & dat_req);
  assign src_dat = sel_dat ? iq_smp_t'(DAT_DAT_I) : iq_smp_t'(PRE_DAT_I);

  tx_out_stage u_out (
    .clk_i    (CLK_I),
    .rst_i    (RST_I),
    .in_vld_i (out_vld),
    .in_dat_i (src_dat),
    .in_rdy_o (out_rdy),
    .dat_o    (out_dat),
    .stb_o    (STB_O),
    .we_o     (WE_O),
    .ack_i    (ACK_I)
  );

  assign DAT_O = out_dat;
  assign CYC_O = cyc_q;
  assign BUSY  = (state_q != ST_IDLE);
  assign DONE  = done;

  // Frame sequencing: counters advance only on source beats, gap only once the entry is empty
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    nsym_d  = nsym_q;
    gap_d   = gap_q;
    cyc_d   = cyc_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (FRM_START) begin
          nsym_d  = NSYM;
          cnt_d   = '0;
          sym_d   = '0;
          gap_d   = '0;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (pre_beat) begin
          cyc_d = 1'b1;
          if (cnt_q == CNT_W'(PRE_LEN - 1)) begin
            cnt_d   = '0;
            state_d = (nsym_q == '0) ? ST_GAP : ST_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (dat_beat) begin
          if (cnt_q == CNT_W'(SYM_LEN - 1)) begin
            cnt_d = '0;
            if (sym_q == nsym_q - 1'b1) begin
              sym_d   = '0;
              state_d = ST_GAP;
            end else begin
              sym_d = sym_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        // The entry can only hold the frame's last sample here
        if (STB_O && ACK_I) begin
          cyc_d = 1'b0;
        end
        if (!STB_O) begin
          if (gap_q == GAP_W'(GAP_LEN - 1)) begin
            gap_d   = '0;
            done    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler state registers; reset aborts the frame immediately
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      nsym_q  <= '0;
      gap_q   <= '0;
      cyc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      nsym_q  <= nsym_d;
      gap_q   <= gap_d;
      cyc_q   <= cyc_d;
    end
  end

endmodule
